main_memory: RTL and testbench
==============================

Name: main_memory

Overview:
- Single-port synchronous main-memory model: a word-addressed array of DATA_W-bit words with registered read data and synchronous write.
- Sits behind the CPU/cache memory interface; one access slot per clock.
- Upper address bits are ignored, so the address space aliases modulo DEPTH.

Parameters:
- DATA_W, 32, width of din, dout and each memory word.
- ADDR_W, 32, width of the addr port.
- DEPTH, 4096, number of words; must be a power of two, at least 2 and at most 2^ADDR_W.
- IDX_W, log2(DEPTH) (default 12), derived value, not overridable; number of addr bits decoded.

Ports:
- clk  in  1  clock; all activity on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising clk edge.
- addr  in  ADDR_W  word address; only addr[IDX_W-1:0] is decoded.
- rEnable  in  1  read request for the current cycle.
- wEnable  in  1  write request for the current cycle.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Index: idx = addr[IDX_W-1:0]. Upper bits are ignored, with no error signal and no fault.
- Example (defaults): 32'h0121800 and 32'h0111800 both map to idx 12'h800.
- Storage: DEPTH x DATA_W array, every word initialised to 0 at start of simulation or configuration. Reset does not clear the array.
- Reset: while rst_n = 0 at a rising edge, dout <= 0 and any write or read in that cycle is suppressed.
- Write: on a rising edge with rst_n = 1 and wEnable = 1, mem[idx] <= din. The word is visible to reads starting the next cycle.
- Read: on a rising edge with rst_n = 1 and rEnable = 1, dout <= mem[idx]. Latency is 1 cycle, and dout is valid after that edge.
- Idle: when rEnable = 0 (no reset), dout holds its previous value. This holds whether or not a write occurs.
- Simultaneous read and write in the same cycle are read-first: dout gets the old contents of mem[idx] and the array gets din.
- Different-alias addresses that map to the same idx behave exactly as the same address.
- No handshake and no stall: every request completes in the cycle it is sampled.
- Inputs are sampled only at rising edges; changes between edges have no effect.
- Reset mid-operation: a write coincident with reset is dropped, and the array keeps its prior contents.
- Synthesis: the array must infer a single-port block RAM (registered output, read-first mode). No asynchronous read path.

Test Plan:
- Write-then-read: addr = 0, din = 32'h0221700, wEnable = 1 for one edge, then rEnable = 1 -> dout = 32'h0221700 one edge after the read.
- Unwritten word: read addr = 32'h0121800 -> dout = 0 (initial contents).
- Read-first collision: addr = 32'h0121800, din = 32'h0021a00, rEnable = wEnable = 1 -> dout = 0 that edge. Next edge with rEnable = 1, wEnable = 0 -> dout = 32'h0021a00.
- Aliasing: after the write above, read addr = 32'h0111800 -> dout = 32'h0021a00. Read addr = 32'h0000800 -> same value.
- Hold and idle: rEnable = wEnable = 0 for 5 cycles while addr and din change -> dout unchanged and array unchanged (verify by reading back afterwards).
- Reset: drive rst_n = 0 for one edge with wEnable = 1, din = 32'hDEADBEEF, addr = 0 -> dout = 0 and mem[0] still 32'h0221700 on a following read.

Source files
------------

// File: rtl/main_memory.sv
// ---------------------------------------------------------------------------
// main_memory
//
// Single-port synchronous main-memory model.
// - A word-addressed array of DEPTH x DATA_W words.
// - Writes are synchronous.
// - Read data is registered, so it appears one cycle after the read.
// - Only the low IDX_W address bits are decoded. Higher addresses alias
//   modulo DEPTH.
// - When a read and a write hit the same cycle, the read returns the old
//   word (read-first), which matches single-port block RAM behaviour.
//
// Ports:
//   clk      in   1       clock, rising-edge active
//   rst_n    in   1       synchronous active-low reset (clears dout only)
//   addr     in   ADDR_W  word address, low IDX_W bits decoded
//   rEnable  in   1       read request this cycle
//   wEnable  in   1       write request this cycle
//   din      in   DATA_W  write data
//   dout     out  DATA_W  registered read data, holds when not reading
// ---------------------------------------------------------------------------
module main_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rEnable,
    input  logic              wEnable,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] idx;

    // Storage starts out all-zero.
    // Reset never touches it, so its contents survive rst_n.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    assign idx = addr[IDX_W-1:0];

    // The upper address bits are deliberately ignored.
    // Folding them into an "unused" net keeps that decision visible.
    generate
        if (IDX_W < ADDR_W) begin : g_upper_ignored
            logic unused_upper_addr;
            assign unused_upper_addr = ^addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    // One access slot per clock.
    // - The read samples mem before the write lands, which gives
    //   read-first behaviour.
    // - Reset suppresses both the read and the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            if (wEnable) begin
                mem[idx] <= din;
            end
            if (rEnable) begin
                dout <= mem[idx];
            end
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// ---------------------------------------------------------------------------
// tb_main_memory
//
// Self-checking bench for main_memory (default parameters).
// - Every cycle of stimulus pushes the expected dout into a scoreboard
//   queue. The expected value comes from a word-array reference model.
// - A monitor pops one entry at each falling edge and compares it against
//   dout.
// - Directed accesses run first, followed by randomized traffic with
//   heavy index aliasing and occasional resets.
// ---------------------------------------------------------------------------
module tb_main_memory;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4096;

    typedef struct {
        int          vec;
        logic [31:0] val;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic              rEnable;
    logic              wEnable;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    // Reference model: a plain word array indexed modulo DEPTH,
    // plus the value the read port should currently show.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] ref_dout;

    exp_t scoreboard[$];
    int   vectors_applied;
    int   miscompares;
    int   vec_id;

    main_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .rEnable(rEnable),
        .wEnable(wEnable),
        .din    (din),
        .dout   (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and update the model for that edge.
    // The expectation is queued just after the edge, so the monitor
    // checks it at the following falling edge.
    task automatic applyStimulus(input logic        rst_v,
                                 input logic [31:0] a,
                                 input logic        r,
                                 input logic        w,
                                 input logic [31:0] d);
        exp_t e;
        int   i;
        rst_n   = rst_v;
        addr    = a;
        rEnable = r;
        wEnable = w;
        din     = d;
        i = int'(a % DEPTH);
        if (!rst_v) begin
            ref_dout = '0;
        end else begin
            if (r) ref_dout = ref_mem[i];
            if (w) ref_mem[i] = d;
        end
        vec_id = vec_id + 1;
        e.vec  = vec_id;
        e.val  = ref_dout;
        @(posedge clk);
        #1;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors_applied = vectors_applied + 1;
        if (dout !== e.val) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL dout vec %0d: got %h, expected %h", e.vec, dout, e.val);
        end
    endtask

    // Monitor: compare whenever an expectation is pending.
    always @(negedge clk) begin
        if (scoreboard.size() != 0) begin
            checkOutput(scoreboard.pop_front());
        end
    end

    initial begin
        logic [11:0] pool [8];
        logic [31:0] a;
        logic        rst_v;
        int          drain;

        vectors_applied = 0;
        miscompares     = 0;
        vec_id          = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_dout = '0;
        rst_n    = 1'b0;
        addr     = '0;
        rEnable  = 1'b0;
        wEnable  = 1'b0;
        din      = '0;
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        // Write-then-read
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'h0221700);
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        // Unwritten word
        applyStimulus(1'b1, 32'h0121800, 1'b1, 1'b0, 32'h0);
        // Read-first collision, then readback
        applyStimulus(1'b1, 32'h0121800, 1'b1, 1'b1, 32'h0021a00);
        applyStimulus(1'b1, 32'h0121800, 1'b1, 1'b0, 32'h0);
        // Aliases of the same index
        applyStimulus(1'b1, 32'h0111800, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0 | 1'b1, 32'h0000800, 1'b1, 1'b0, 32'h0);
        // Idle cycles with wandering addr/din: dout must hold
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, $urandom, 1'b0, 1'b0, $urandom);
        end
        applyStimulus(1'b1, 32'h0000800, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        // Write during reset is dropped
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);

        // Randomized traffic over a small set of indices with random upper bits
        pool[0] = 12'h000; pool[1] = 12'h001; pool[2] = 12'h800; pool[3] = 12'hFFF;
        pool[4] = 12'h7FF; pool[5] = 12'h123; pool[6] = 12'h555; pool[7] = 12'hAAA;
        for (int k = 0; k < 400; k++) begin
            a     = ($urandom & 32'hFFFF_F000) | {20'h0, pool[$urandom_range(0, 7)]};
            rst_v = ($urandom_range(0, 31) != 0);
            applyStimulus(rst_v, a, 1'($urandom), 1'($urandom), $urandom);
        end

        // Let the monitor drain, bounded
        rEnable = 1'b0;
        wEnable = 1'b0;
        drain = 0;
        while (scoreboard.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (scoreboard.size() != 0) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL drain: %0d pending, expected 0", scoreboard.size());
        end
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
